// File: rtl/sc_microsequencer_pkg.sv
// -----------------------------------------------------------------------------
// sc_microseq_pkg
// Shared definitions for the ARC microprogram sequencer:
//   - microinstruction condition codes (COND_NEXT .. COND_WAIT)
//   - flag bit positions inside the {N,Z,V,C} PSR
//   - helpers that locate the JumpAddr and Cond fields inside a microword
// -----------------------------------------------------------------------------
package sc_microseq_pkg;

  // Condition codes carried in the Cond field of the microword.
  localparam int unsigned COND_NEXT   = 0;
  localparam int unsigned COND_N      = 1;
  localparam int unsigned COND_Z      = 2;
  localparam int unsigned COND_V      = 3;
  localparam int unsigned COND_C      = 4;
  localparam int unsigned COND_IR13   = 5;
  localparam int unsigned COND_JMP    = 6;
  localparam int unsigned COND_DECODE = 7;
  localparam int unsigned COND_CALL   = 8;
  localparam int unsigned COND_RET    = 9;
  localparam int unsigned COND_WAIT   = 10;

  // Flag order is {N,Z,V,C}, so C sits in bit 0.
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // JumpAddr occupies the low AW bits of the microword.
  function automatic int jump_lsb();
    return 0;
  endfunction

  // Cond sits directly above JumpAddr.
  function automatic int cond_lsb(input int aw);
    return aw;
  endfunction

endpackage

// File: rtl/sc_microsequencer_if.sv
// -----------------------------------------------------------------------------
// sc_microsequencer_if
// Bundles every non-clock/reset signal of the sequencer:
//   datapath status in  : Flags_In, FlagsWr_InLow, IR13_In, IR_OP_In, MemReady_In
//   control store bus   : CS_Addr_Out (to store), CS_Data_In (from store)
//   sequencer results   : MIR_Out, PSR_Out, Stall_Out, StackErr_Out
// master = sequencer side, slave = datapath / control-store side.
// -----------------------------------------------------------------------------
interface sc_microsequencer_if #(
  parameter int AW  = 11,
  parameter int MW  = 41,
  parameter int OPW = 8,
  parameter int FW  = 4
) ();

  logic [FW-1:0]  SC_MicroSeq_Flags_In;
  logic           SC_MicroSeq_FlagsWr_InLow;
  logic           SC_MicroSeq_IR13_In;
  logic [OPW-1:0] SC_MicroSeq_IR_OP_In;
  logic           SC_MicroSeq_MemReady_In;
  logic [MW-1:0]  SC_MicroSeq_CS_Data_In;
  logic [AW-1:0]  SC_MicroSeq_CS_Addr_Out;
  logic [MW-1:0]  SC_MicroSeq_MIR_Out;
  logic [FW-1:0]  SC_MicroSeq_PSR_Out;
  logic           SC_MicroSeq_Stall_Out;
  logic           SC_MicroSeq_StackErr_Out;

  modport master (
    input  SC_MicroSeq_Flags_In, SC_MicroSeq_FlagsWr_InLow, SC_MicroSeq_IR13_In,
           SC_MicroSeq_IR_OP_In, SC_MicroSeq_MemReady_In, SC_MicroSeq_CS_Data_In,
    output SC_MicroSeq_CS_Addr_Out, SC_MicroSeq_MIR_Out, SC_MicroSeq_PSR_Out,
           SC_MicroSeq_Stall_Out, SC_MicroSeq_StackErr_Out
  );

  modport slave (
    output SC_MicroSeq_Flags_In, SC_MicroSeq_FlagsWr_InLow, SC_MicroSeq_IR13_In,
           SC_MicroSeq_IR_OP_In, SC_MicroSeq_MemReady_In, SC_MicroSeq_CS_Data_In,
    input  SC_MicroSeq_CS_Addr_Out, SC_MicroSeq_MIR_Out, SC_MicroSeq_PSR_Out,
           SC_MicroSeq_Stall_Out, SC_MicroSeq_StackErr_Out
  );

endinterface

// File: rtl/sc_microsequencer_return_stack.sv
// -----------------------------------------------------------------------------
// sc_return_stack
// LIFO of microaddresses used by CALL/RET.
//   i_clk, i_rst      clock, synchronous active-high reset (clears SP only)
//   i_push, i_addr    push i_addr (ignored when full)
//   i_pop             discard top entry (ignored when empty)
//   o_full, o_empty   SP == DEPTH / SP == 0
//   o_top             most recently pushed entry, valid when !o_empty
// The top is read combinationally so a RET can redirect fetch in the same
// cycle, and a CALL in the following word sees the already-updated SP.
// -----------------------------------------------------------------------------
module sc_return_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 11
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_addr,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW-1:0] o_top
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0] r_sp;
  logic [AW-1:0]  r_mem [DEPTH];
  logic [IW-1:0]  w_wr_idx;
  logic [IW-1:0]  w_rd_idx;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_sp == SPW'(DEPTH));
  assign o_empty   = (r_sp == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_wr_idx  = IW'(r_sp);
  assign w_rd_idx  = IW'(r_sp - SPW'(1));
  assign o_top     = r_mem[w_rd_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SPW'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SPW'(1);
    end
  end

  // NOTE: storage is deliberately left out of reset; SP alone defines which
  // entries are live, so resetting the array would only add reset fan-out.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_addr;
    end
  end

endmodule

// File: rtl/sc_microsequencer.sv
// -----------------------------------------------------------------------------
// sc_microsequencer
// Microprogram sequencer for the ARC control unit. Holds uPC, PSR and MIR,
// selects the next microaddress and presents it combinationally to an
// external control store whose word returns in the same cycle.
//   SC_MicroSeq_CLOCK_50      clock, rising edge
//   SC_MicroSeq_RESET_InHigh  synchronous reset, active high
//   bus (master)              flags/IR/memory-ready in, control-store bus,
//                             MIR/PSR/Stall/StackErr out
// Cond field: NEXT, N, Z, V, C, IR13, JMP, DECODE, CALL, RET, WAIT; any
// other code behaves as NEXT.
// -----------------------------------------------------------------------------
module sc_microsequencer
  import sc_microseq_pkg::*;
#(
  parameter int AW          = 11,
  parameter int MW          = 41,
  parameter int CW          = 4,
  parameter int OPW         = 8,
  parameter int STACK_DEPTH = 4,
  parameter int FW          = 4
) (
  input logic               SC_MicroSeq_CLOCK_50,
  input logic               SC_MicroSeq_RESET_InHigh,
  sc_microsequencer_if.master bus
);

  localparam int JUMP_LSB = jump_lsb();
  localparam int COND_LSB = cond_lsb(AW);

  logic [AW-1:0] r_upc;
  logic [MW-1:0] r_mir;
  logic [FW-1:0] r_psr;
  logic          r_stack_err;

  logic [CW-1:0] w_cond;
  logic [31:0]   w_cond_code;
  logic [AW-1:0] w_jump;
  logic [AW-1:0] w_csai;
  logic [AW-1:0] w_decode;
  logic [AW-1:0] w_next;
  logic [AW-1:0] w_stack_top;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_set_err;
  logic          w_stall;

  assign w_cond      = r_mir[COND_LSB +: CW];
  assign w_cond_code = 32'(w_cond);
  assign w_jump      = r_mir[JUMP_LSB +: AW];
  assign w_csai      = r_upc + AW'(1);
  // Opcode lands just below a leading 1, giving each opcode its own
  // 2^(AW-OPW-1)-word slot in the upper half of the control store.
  assign w_decode    = (AW'(1) << (AW - 1)) |
                       (AW'(bus.SC_MicroSeq_IR_OP_In) << (AW - OPW - 1));

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next    = w_csai;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_err = 1'b0;
    w_stall   = 1'b0;
    case (w_cond_code)
      COND_N:      if (r_psr[FLAG_N]) w_next = w_jump;
      COND_Z:      if (r_psr[FLAG_Z]) w_next = w_jump;
      COND_V:      if (r_psr[FLAG_V]) w_next = w_jump;
      COND_C:      if (r_psr[FLAG_C]) w_next = w_jump;
      COND_IR13:   if (bus.SC_MicroSeq_IR13_In) w_next = w_jump;
      COND_JMP:    w_next = w_jump;
      COND_DECODE: w_next = w_decode;
      COND_CALL: begin
        // Overflow degrades to NEXT and flags the error.
        if (w_full) begin
          w_set_err = 1'b1;
        end else begin
          w_push = 1'b1;
          w_next = w_jump;
        end
      end
      COND_RET: begin
        if (w_empty) begin
          w_set_err = 1'b1;
        end else begin
          w_pop  = 1'b1;
          w_next = w_stack_top;
        end
      end
      COND_WAIT: begin
        // Re-present the current address so the same word is refetched.
        if (!bus.SC_MicroSeq_MemReady_In) begin
          w_next  = r_upc;
          w_stall = 1'b1;
        end
      end
      default: ;
    endcase
  end

  sc_return_stack #(
    .DEPTH (STACK_DEPTH),
    .AW    (AW)
  ) u_stack (
    .i_clk   (SC_MicroSeq_CLOCK_50),
    .i_rst   (SC_MicroSeq_RESET_InHigh),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_addr  (w_csai),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_top   (w_stack_top)
  );

  // NOTE: state registers use non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge SC_MicroSeq_CLOCK_50) begin
    if (SC_MicroSeq_RESET_InHigh) begin
      // uPC of all ones plus MIR=0 (NEXT) makes the first fetch address 0.
      r_upc       <= '1;
      r_mir       <= '0;
      r_psr       <= '0;
      r_stack_err <= 1'b0;
    end else begin
      r_upc <= w_next;
      r_mir <= bus.SC_MicroSeq_CS_Data_In;
      if (!bus.SC_MicroSeq_FlagsWr_InLow) begin
        r_psr <= bus.SC_MicroSeq_Flags_In;
      end
      if (w_set_err) begin
        r_stack_err <= 1'b1;
      end
    end
  end

  assign bus.SC_MicroSeq_CS_Addr_Out  = w_next;
  assign bus.SC_MicroSeq_MIR_Out      = r_mir;
  assign bus.SC_MicroSeq_PSR_Out      = r_psr;
  assign bus.SC_MicroSeq_Stall_Out    = w_stall;
  assign bus.SC_MicroSeq_StackErr_Out = r_stack_err;

endmodule

// File: tb/tb_sc_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_sc_microsequencer
// Drives the sequencer against a behavioural control store. Each step drives
// inputs on the falling edge, compares the combinational address, stall,
// stack-error and PSR, and pushes the microword expected in MIR after the
// next rising edge onto a queue that the following step pops and compares.
// -----------------------------------------------------------------------------
module tb_sc_microsequencer;
  import sc_microseq_pkg::*;

  localparam int AW  = 11;
  localparam int MW  = 41;
  localparam int CW  = 4;
  localparam int OPW = 8;
  localparam int FW  = 4;

  typedef struct {
    logic          rst;
    logic [FW-1:0] flags;
    logic          fwr_n;
    logic          ir13;
    logic [7:0]    op;
    logic          mrdy;
    logic [AW-1:0] addr;
    logic          stall;
    logic          err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  sc_microsequencer_if #(.AW(AW), .MW(MW), .OPW(OPW), .FW(FW)) bus ();

  sc_microsequencer #(
    .AW(AW), .MW(MW), .CW(CW), .OPW(OPW), .STACK_DEPTH(4), .FW(FW)
  ) dut (
    .SC_MicroSeq_CLOCK_50     (clk),
    .SC_MicroSeq_RESET_InHigh (rst),
    .bus                      (bus)
  );

  always #5 clk = ~clk;

  logic [MW-1:0] rom [2**AW];
  assign bus.SC_MicroSeq_CS_Data_In = rom[bus.SC_MicroSeq_CS_Addr_Out];

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [MW-1:0] mir_q [$];
  logic [FW-1:0] psr_exp;
  vec_t          tbl [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_word(input int a, input int unsigned cond, input int jump);
    rom[a][CW+AW-1:0] = {CW'(cond), AW'(jump)};
  endtask

  function automatic vec_t mk(input logic r, input logic [FW-1:0] f, input logic fw,
                              input logic i13, input logic [7:0] op, input logic rdy,
                              input int a, input logic st, input logic er);
    vec_t v;
    v.rst = r; v.flags = f; v.fwr_n = fw; v.ir13 = i13; v.op = op; v.mrdy = rdy;
    v.addr = AW'(a); v.stall = st; v.err = er;
    return v;
  endfunction

  // Plain step with idle inputs.
  function automatic vec_t nx(input int a, input logic er);
    return mk(1'b0, '0, 1'b1, 1'b0, 8'h00, 1'b1, a, 1'b0, er);
  endfunction

  task automatic apply(input vec_t v, input string tag);
    logic [MW-1:0] exp_mir;
    @(negedge clk);
    rst                           = v.rst;
    bus.SC_MicroSeq_Flags_In      = v.flags;
    bus.SC_MicroSeq_FlagsWr_InLow = v.fwr_n;
    bus.SC_MicroSeq_IR13_In       = v.ir13;
    bus.SC_MicroSeq_IR_OP_In      = v.op;
    bus.SC_MicroSeq_MemReady_In   = v.mrdy;
    #1;
    exp_mir = '0;
    if (mir_q.size() != 0) exp_mir = mir_q.pop_front();
    check({tag, " mir"},   64'(bus.SC_MicroSeq_MIR_Out),      64'(exp_mir));
    check({tag, " addr"},  64'(bus.SC_MicroSeq_CS_Addr_Out),  64'(v.addr));
    check({tag, " stall"}, 64'(bus.SC_MicroSeq_Stall_Out),    64'(v.stall));
    check({tag, " err"},   64'(bus.SC_MicroSeq_StackErr_Out), 64'(v.err));
    check({tag, " psr"},   64'(bus.SC_MicroSeq_PSR_Out),      64'(psr_exp));
    mir_q.push_back(v.rst ? '0 : rom[v.addr]);
    @(posedge clk);
    if (v.rst) psr_exp = '0;
    else if (!v.fwr_n) psr_exp = v.flags;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Default store: NEXT everywhere, non-zero jump field and a per-address marker.
    for (int a = 0; a < 2**AW; a++) rom[a] = {26'(a * 7 + 3), 4'(COND_NEXT), 11'(~a)};
    set_word(12'h003, COND_JMP, 12'h020);
    set_word(12'h020, COND_Z, 12'h100);
    set_word(12'h100, COND_Z, 12'h300);
    set_word(12'h101, COND_JMP, 12'h030);
    set_word(12'h030, COND_DECODE, 0);
    set_word(12'h628, COND_IR13, 12'h040);
    set_word(12'h040, COND_IR13, 12'h300);
    set_word(12'h042, COND_N, 12'h045);
    set_word(12'h045, COND_V, 12'h300);
    set_word(12'h046, COND_C, 12'h010);
    set_word(12'h010, COND_CALL, 12'h200);
    set_word(12'h200, COND_CALL, 12'h210);
    set_word(12'h210, COND_CALL, 12'h220);
    set_word(12'h220, COND_CALL, 12'h230);
    set_word(12'h230, COND_CALL, 12'h240);
    set_word(12'h231, COND_RET, 0);
    set_word(12'h221, COND_RET, 0);
    set_word(12'h211, COND_RET, 0);
    set_word(12'h201, COND_RET, 0);
    set_word(12'h011, COND_RET, 0);
    set_word(12'h012, COND_CALL, 12'h250);
    set_word(12'h250, COND_RET, 0);
    set_word(12'h013, COND_JMP, 12'h050);
    set_word(12'h050, COND_WAIT, 0);
    set_word(12'h051, COND_JMP, 12'h7FE);
    set_word(12'h021, COND_CALL, 12'h060);
    set_word(12'h060, COND_CALL, 12'h070);
    set_word(12'h070, COND_WAIT, 0);
    set_word(12'h071, COND_RET, 0);
    set_word(12'h061, COND_RET, 0);
    set_word(12'h022, COND_RET, 0);

    // Reset and sequential fetch from 0.
    tbl.push_back(mk(1'b1, '0, 1'b1, 1'b0, 8'h00, 1'b1, 12'h000, 1'b0, 1'b0));
    tbl.push_back(nx(12'h000, 1'b0));
    tbl.push_back(nx(12'h001, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0100, 1'b0, 1'b0, 8'h00, 1'b1, 12'h002, 1'b0, 1'b0));
    tbl.push_back(nx(12'h003, 1'b0));
    tbl.push_back(nx(12'h020, 1'b0));
    // Z taken on registered PSR even though Z is cleared this same cycle.
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b1, 12'h100, 1'b0, 1'b0));
    tbl.push_back(nx(12'h101, 1'b0));
    tbl.push_back(nx(12'h030, 1'b0));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 8'h8A, 1'b1, 12'h628, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 8'h00, 1'b1, 12'h040, 1'b0, 1'b0));
    tbl.push_back(nx(12'h041, 1'b0));
    tbl.push_back(mk(1'b0, 4'b1001, 1'b0, 1'b0, 8'h00, 1'b1, 12'h042, 1'b0, 1'b0));
    tbl.push_back(nx(12'h045, 1'b0));
    tbl.push_back(nx(12'h046, 1'b0));
    tbl.push_back(nx(12'h010, 1'b0));
    // Four nested CALLs, overflow, four RETs in LIFO order, underflow.
    tbl.push_back(nx(12'h200, 1'b0));
    tbl.push_back(nx(12'h210, 1'b0));
    tbl.push_back(nx(12'h220, 1'b0));
    tbl.push_back(nx(12'h230, 1'b0));
    tbl.push_back(nx(12'h231, 1'b0));
    tbl.push_back(nx(12'h221, 1'b1));
    tbl.push_back(nx(12'h211, 1'b1));
    tbl.push_back(nx(12'h201, 1'b1));
    tbl.push_back(nx(12'h011, 1'b1));
    tbl.push_back(nx(12'h012, 1'b1));
    tbl.push_back(nx(12'h250, 1'b1));
    tbl.push_back(nx(12'h013, 1'b1));
    tbl.push_back(nx(12'h050, 1'b1));
    // WAIT: three stalled cycles (PSR still loads), then release.
    tbl.push_back(mk(1'b0, 4'b0010, 1'b0, 1'b0, 8'h00, 1'b0, 12'h050, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 8'h00, 1'b0, 12'h050, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 8'h00, 1'b0, 12'h050, 1'b1, 1'b1));
    tbl.push_back(nx(12'h051, 1'b1));
    tbl.push_back(nx(12'h7FE, 1'b1));
    tbl.push_back(nx(12'h7FF, 1'b1));
    tbl.push_back(nx(12'h000, 1'b1));
    tbl.push_back(nx(12'h001, 1'b1));

    rst                           = 1'b1;
    bus.SC_MicroSeq_Flags_In      = '0;
    bus.SC_MicroSeq_FlagsWr_InLow = 1'b1;
    bus.SC_MicroSeq_IR13_In       = 1'b0;
    bus.SC_MicroSeq_IR_OP_In      = '0;
    bus.SC_MicroSeq_MemReady_In   = 1'b1;
    psr_exp = '0;
    mir_q.push_back('0);
    @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset during a stall with two return addresses stacked.
    apply(nx(12'h002, 1'b1), "t6_a");
    apply(nx(12'h003, 1'b1), "t6_b");
    apply(nx(12'h020, 1'b1), "t6_c");
    apply(nx(12'h021, 1'b1), "t6_d");
    apply(nx(12'h060, 1'b1), "t6_e");
    apply(nx(12'h070, 1'b1), "t6_f");
    for (int k = 0; k < 2; k++)
      apply(mk(1'b0, '0, 1'b1, 1'b0, 8'h00, 1'b0, 12'h070, 1'b1, 1'b1), $sformatf("t6_stall%0d", k));
    apply(mk(1'b1, '0, 1'b1, 1'b0, 8'h00, 1'b0, 12'h070, 1'b1, 1'b1), "t6_rst0");
    apply(mk(1'b1, '0, 1'b1, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0), "t6_rst1");
    // Fresh run: two CALLs then three RETs must underflow on the third.
    apply(nx(12'h000, 1'b0), "t6_g");
    apply(nx(12'h001, 1'b0), "t6_h");
    apply(nx(12'h002, 1'b0), "t6_i");
    apply(nx(12'h003, 1'b0), "t6_j");
    apply(nx(12'h020, 1'b0), "t6_k");
    apply(nx(12'h021, 1'b0), "t6_l");
    apply(nx(12'h060, 1'b0), "t6_m");
    apply(nx(12'h070, 1'b0), "t6_n");
    apply(nx(12'h071, 1'b0), "t6_o");
    apply(nx(12'h061, 1'b0), "t6_p");
    apply(nx(12'h022, 1'b0), "t6_q");
    apply(nx(12'h023, 1'b0), "t6_r");
    apply(nx(12'h024, 1'b1), "t6_s");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
